// File: rtl/mem_responder.sv
// Memory-side responder: accepts a mem_EN/mem_RW request, accesses a word array after WAIT wait states, then holds MFC until mem_EN drops.
// Latency: MFC rises WAIT edges after accept (same edge when WAIT=0). Four-phase handshake; new requests are taken only from IDLE.
module mem_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_EN,
  input  logic              mem_RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              MFC,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mfc_q, mfc_d;
  logic                busy_q, busy_d;

  logic                enter_done;
  logic                mem_we;
  logic [IDX_W-1:0]    acc_addr;
  logic                acc_rw;
  logic [DATA_W-1:0]   acc_wdata;
  logic                unused_addr;

  logic [DATA_W-1:0]   mem [DEPTH];

  // High address bits are discarded by design (address wrap).
  assign unused_addr = ^addr;

  // With WAIT=0 the access happens on the accept edge, before the latches are loaded.
  always_comb begin
    acc_addr  = addr_q;
    acc_rw    = rw_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_addr  = addr[IDX_W-1:0];
      acc_rw    = mem_RW;
      acc_wdata = wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_EN) begin
          addr_d  = addr[IDX_W-1:0];
          rw_d    = mem_RW;
          wdata_d = wdata;
          if (WAIT == 0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_CNT;
          end
        end
      end
      S_WAIT: begin
        if (!mem_EN) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d    = S_DONE;
          cnt_d      = 4'd0;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (!mem_EN) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (enter_done && acc_rw) begin
      rdata_d = mem[acc_addr];
    end
  end

  assign mfc_d  = (state_d == S_DONE);
  assign busy_d = (state_d != S_IDLE);
  // Gate with rst so a write racing an asserted reset is never committed.
  assign mem_we = enter_done && !acc_rw && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      mfc_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mfc_q   <= mfc_d;
      busy_q  <= busy_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  assign rdata = rdata_q;
  assign MFC   = mfc_q;
  assign busy  = busy_q;

endmodule
